// File: rtl/bmem_line_arbiter.sv
// Line-wide memory front end shared by the I-side and D-side L2 caches.
// Picks one client at a time (round-robin on ties), then moves the whole
// line over the 64-bit burst port: writes are streamed out beat by beat,
// and read beats are gathered back into a full line.
module bmem_line_arbiter #(
    parameter int  LOG2_WORDSIZE = 10,
    localparam int LINE_W        = 2 ** LOG2_WORDSIZE,
    localparam int BEATS         = 2 ** (LOG2_WORDSIZE - 6)
) (
    input  logic              clk,
    input  logic              rst,

    input  logic [31:0]       i_address,
    input  logic              i_read,
    input  logic              i_write,
    input  logic [LINE_W-1:0] i_wdata,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,

    input  logic [31:0]       d_address,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,

    output logic [31:0]       bmem_address,
    output logic              bmem_read,
    output logic              bmem_write,
    output logic [63:0]       bmem_wdata,
    input  logic [63:0]       bmem_rdata,
    input  logic              bmem_resp
);

    localparam int          CNT_W      = LOG2_WORDSIZE - 6;
    // Clears the byte offset inside a line (LINE_W/8 bytes per line).
    localparam logic [31:0] ALIGN_MASK = ~((32'd1 << (LOG2_WORDSIZE - 3)) - 32'd1);

    typedef enum logic [2:0] {
        IDLE,
        RD_CMD,
        RD_BEATS,
        WR_BEATS,
        WR_WAIT,
        DONE
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic [CNT_W-1:0]    cnt_q;
    logic                grant_q;       // 1 = D-side owns the current transaction
    logic                last_grant_q;  // 1 = D-side was served last
    logic [31:0]         addr_q;
    logic [LINE_W-1:0]   wdata_q;
    logic [LINE_W-1:0]   line_q;
    logic [LINE_W-1:0]   line_next;

    logic                i_req;
    logic                d_req;
    logic                pick_d;
    logic                pick_write;
    logic                last_beat;
    logic                addr_valid;
    logic [LOG2_WORDSIZE-1:0] bit_off;

    assign i_req      = i_read | i_write;
    assign d_req      = d_read | d_write;
    // On a tie the client that was not served last wins.
    assign pick_d     = d_req & (~i_req | ~last_grant_q);
    // Read and write together from one client is treated as a write.
    assign pick_write = pick_d ? d_write : i_write;
    assign last_beat  = (cnt_q == CNT_W'(BEATS - 1));
    assign bit_off    = {cnt_q, 6'd0};

    // Next-state logic and state-decoded outputs; nothing here depends on client inputs except the IDLE branch.
    always_comb begin
        state_d    = state_q;
        bmem_read  = 1'b0;
        bmem_write = 1'b0;
        bmem_wdata = '0;
        addr_valid = 1'b0;
        i_resp     = 1'b0;
        d_resp     = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_req || d_req) begin
                    state_d = pick_write ? WR_BEATS : RD_CMD;
                end
            end
            RD_CMD: begin
                bmem_read  = 1'b1;
                addr_valid = 1'b1;
                state_d    = RD_BEATS;
            end
            RD_BEATS: begin
                addr_valid = 1'b1;
                if (bmem_resp && last_beat) begin
                    state_d = DONE;
                end
            end
            WR_BEATS: begin
                bmem_write = 1'b1;
                bmem_wdata = wdata_q[bit_off +: 64];
                addr_valid = 1'b1;
                if (last_beat) begin
                    state_d = WR_WAIT;
                end
            end
            WR_WAIT: begin
                addr_valid = 1'b1;
                if (bmem_resp) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                i_resp  = ~grant_q;
                d_resp  = grant_q;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bmem_address = addr_valid ? (addr_q & ALIGN_MASK) : 32'd0;

    // Current line buffer with the incoming read beat merged into slot cnt_q.
    always_comb begin
        line_next = line_q;
        line_next[bit_off +: 64] = bmem_rdata;
    end

    // Control state: FSM register, beat counter, grant tracking and the per-client read lines.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b0;
            i_rdata      <= '0;
            d_rdata      <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    cnt_q <= '0;
                    if (i_req || d_req) begin
                        grant_q <= pick_d;
                    end
                end
                RD_BEATS: begin
                    if (bmem_resp) begin
                        if (!last_beat) begin
                            cnt_q <= cnt_q + 1'b1;
                        end else if (grant_q) begin
                            d_rdata <= line_next;
                        end else begin
                            i_rdata <= line_next;
                        end
                    end
                end
                WR_BEATS: begin
                    if (!last_beat) begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                DONE: begin
                    last_grant_q <= grant_q;
                end
                default: begin
                end
            endcase
        end
    end

    // Datapath capture: request address/write line at grant, read beats as they arrive.
    always_ff @(posedge clk) begin
        if (state_q == IDLE && (i_req || d_req)) begin
            addr_q  <= pick_d ? d_address : i_address;
            wdata_q <= pick_d ? d_wdata : i_wdata;
        end
        if (state_q == RD_BEATS && bmem_resp) begin
            line_q <= line_next;
        end
    end

endmodule

// File: tb/tb_bmem_line_arbiter.sv
// Bench for bmem_line_arbiter: a vector table of arbitration/transfer cases,
// hand sequences for reset and rd+wr corners, and randomized traffic against
// a round-robin reference model.
module tb_bmem_line_arbiter;

    logic          clk = 1'b0;
    logic          rst;
    logic [31:0]   i_address, d_address;
    logic          i_read, i_write, d_read, d_write;
    logic [1023:0] i_wdata, d_wdata, i_rdata, d_rdata;
    logic          i_resp, d_resp;
    logic [31:0]   bmem_address;
    logic          bmem_read, bmem_write;
    logic [63:0]   bmem_wdata, bmem_rdata;
    logic          bmem_resp;

    bmem_line_arbiter #(.LOG2_WORDSIZE(10)) dut (
        .clk(clk), .rst(rst),
        .i_address(i_address), .i_read(i_read), .i_write(i_write),
        .i_wdata(i_wdata), .i_rdata(i_rdata), .i_resp(i_resp),
        .d_address(d_address), .d_read(d_read), .d_write(d_write),
        .d_wdata(d_wdata), .d_rdata(d_rdata), .d_resp(d_resp),
        .bmem_address(bmem_address), .bmem_read(bmem_read), .bmem_write(bmem_write),
        .bmem_wdata(bmem_wdata), .bmem_rdata(bmem_rdata), .bmem_resp(bmem_resp)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Line is 128 bytes, so the low 7 address bits are dropped.
    localparam logic [31:0] LINE_MASK = 32'hFFFF_FF80;

    logic [63:0]   rd_beats[16];
    logic [63:0]   wr_seen[16];
    int            n_rd, n_wr, rd_cyc, wr_first, wr_last, resp_cyc, got_i, got_d;
    logic [31:0]   addr_seen;
    logic [1023:0] cap_i, cap_d;

    // Reference model state: who was served last (1 = D) and each client's visible read line.
    logic          model_last;
    logic [1023:0] model_i, model_d;

    typedef struct {
        bit          ir, iw, dr, dw;
        logic [31:0] ia, da;
        int          gap;
        bit          noise;
        logic [63:0] iseed, dseed, rseed;
        bit          exp_d, exp_wr;
        logic [31:0] exp_addr;
    } vec_t;

    vec_t tbl[12];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h", nm, act, exp);
        end
    endtask

    task automatic chk_line(input string nm, input logic [1023:0] act, input logic [1023:0] exp);
        int k;
        k = 0;
        checks++;
        if (act !== exp) begin
            errors++;
            for (int j = 15; j >= 0; j--) begin
                if (act[64*j +: 64] !== exp[64*j +: 64]) k = j;
            end
            $display("FAIL %s: beat %0d is %h, required %h", nm, k, act[64*k +: 64], exp[64*k +: 64]);
        end
    endtask

    function automatic logic [1023:0] seq_line(input logic [63:0] seed);
        logic [1023:0] l;
        for (int k = 0; k < 16; k++) l[64*k +: 64] = seed + 64'(k);
        return l;
    endfunction

    function automatic logic [1023:0] rand_line();
        logic [1023:0] l;
        for (int k = 0; k < 32; k++) l[32*k +: 32] = $urandom;
        return l;
    endfunction

    task automatic set_rd_seq(input logic [63:0] seed);
        for (int k = 0; k < 16; k++) rd_beats[k] = seed + 64'(k);
    endtask

    task automatic set_rd_rand();
        for (int k = 0; k < 16; k++) rd_beats[k] = {$urandom, $urandom};
    endtask

    // Acts as the burst memory for one transaction and records what the DUT did.
    // Entered #1 after a rising edge with the DUT idle; cycle 0 is that idle cycle.
    task automatic serve(input int gap, input bit noise);
        int cyc, rd_idx, gapc, wcnt;
        bit rd_active, wr_pend, done;
        cyc = 0; rd_idx = 0; gapc = 0; wcnt = 0;
        rd_active = 0; wr_pend = 0; done = 0;
        n_rd = 0; n_wr = 0; rd_cyc = -1; wr_first = -1; wr_last = -1; resp_cyc = -1;
        got_i = 0; got_d = 0; addr_seen = '0;
        while (!done && cyc < 400) begin
            @(negedge clk);
            if (bmem_read) begin
                n_rd++; rd_cyc = cyc; addr_seen = bmem_address; rd_active = 1;
            end
            if (bmem_write) begin
                if (n_wr < 16) wr_seen[n_wr] = bmem_wdata;
                if (wr_first < 0) wr_first = cyc;
                wr_last = cyc;
                n_wr++;
                addr_seen = bmem_address;
                if (n_wr == 16) begin wr_pend = 1; wcnt = gap; end
            end
            if (i_resp) got_i++;
            if (d_resp) got_d++;
            if (i_resp || d_resp) begin
                done = 1; resp_cyc = cyc; cap_i = i_rdata; cap_d = d_rdata;
            end
            @(posedge clk); #1;
            bmem_resp  = 1'b0;
            bmem_rdata = {$urandom, $urandom};
            if (rd_active && rd_idx < 16) begin
                if (gapc == 0) begin
                    bmem_resp = 1'b1; bmem_rdata = rd_beats[rd_idx]; rd_idx++; gapc = gap;
                end else begin
                    gapc--;
                end
            end else if (wr_pend) begin
                if (wcnt == 0) begin bmem_resp = 1'b1; wr_pend = 0; end
                else wcnt--;
            end else if (noise && (cyc == 0 || (n_wr > 0 && n_wr < 16))) begin
                bmem_resp = 1'b1;
            end
            cyc++;
        end
        if (!done) begin
            checks++; errors++;
            $display("FAIL serve_timeout: no resp after %0d cycles, required one", cyc);
        end
        bmem_resp = 1'b0;
    endtask

    // Runs one granted transaction and checks it against the expectation given.
    task automatic do_txn(input string nm, input bit ir, input bit iw, input bit dr, input bit dw,
                          input logic [31:0] ia, input logic [31:0] da, input int gap, input bit noise,
                          input bit exp_d, input bit exp_wr, input logic [31:0] exp_addr);
        logic [1023:0] exp_line, seen;
        i_read = ir; i_write = iw; d_read = dr; d_write = dw;
        i_address = ia; d_address = da;
        serve(gap, noise);
        if (exp_d) begin d_read = 0; d_write = 0; end
        else begin i_read = 0; i_write = 0; end
        chk({nm, " i_resp pulses"}, 64'(got_i), exp_d ? 64'd0 : 64'd1);
        chk({nm, " d_resp pulses"}, 64'(got_d), exp_d ? 64'd1 : 64'd0);
        chk({nm, " bmem_address"}, 64'(addr_seen), 64'(exp_addr));
        if (exp_wr) begin
            chk({nm, " write beats"}, 64'(n_wr), 64'd16);
            chk({nm, " first write cycle"}, 64'(wr_first), 64'd1);
            chk({nm, " last write cycle"}, 64'(wr_last), 64'd16);
            chk({nm, " read cmds"}, 64'(n_rd), 64'd0);
            chk({nm, " resp cycle"}, 64'(resp_cyc), 64'(18 + gap));
            for (int k = 0; k < 16; k++) seen[64*k +: 64] = wr_seen[k];
            chk_line({nm, " wdata"}, seen, exp_d ? d_wdata : i_wdata);
        end else begin
            chk({nm, " read cmds"}, 64'(n_rd), 64'd1);
            chk({nm, " read cmd cycle"}, 64'(rd_cyc), 64'd1);
            chk({nm, " write beats"}, 64'(n_wr), 64'd0);
            chk({nm, " resp cycle"}, 64'(resp_cyc), 64'(3 + 15 * (gap + 1)));
            for (int k = 0; k < 16; k++) exp_line[64*k +: 64] = rd_beats[k];
            if (exp_d) model_d = exp_line;
            else model_i = exp_line;
        end
        chk_line({nm, " i_rdata"}, cap_i, model_i);
        chk_line({nm, " d_rdata"}, cap_d, model_d);
        model_last = exp_d;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not end, required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit          ir, iw, dr, dw, exp_d, exp_wr, noise;
        int          sel, gap;
        logic [31:0] ia, da;

        //                 ir iw dr dw  ia            da            gap noise iseed               dseed                  rseed     exp_d exp_wr exp_addr
        tbl[0]  = '{1, 0, 1, 0, 32'h0000_1234, 32'h0000_3000, 0, 0, 64'h0, 64'h0,                  64'h100, 1, 0, 32'h0000_3000};
        tbl[1]  = '{1, 0, 0, 0, 32'h0000_1234, 32'h0,         0, 0, 64'h0, 64'h0,                  64'h1,   0, 0, 32'h0000_1200};
        tbl[2]  = '{1, 0, 1, 0, 32'h4000_0080, 32'h4000_0100, 0, 1, 64'h0, 64'h0,                  64'h200, 1, 0, 32'h4000_0100};
        tbl[3]  = '{1, 0, 0, 0, 32'h4000_0080, 32'h0,         3, 0, 64'h0, 64'h0,                  64'h300, 0, 0, 32'h4000_0080};
        tbl[4]  = '{0, 0, 0, 1, 32'h0,         32'h8000_0040, 0, 0, 64'h0, 64'hA5A5_0000_0000_0000, 64'h0,   1, 1, 32'h8000_0000};
        tbl[5]  = '{1, 0, 1, 0, 32'h0000_00FF, 32'h0000_0180, 0, 0, 64'h0, 64'h0,                  64'h500, 0, 0, 32'h0000_0080};
        tbl[6]  = '{0, 0, 1, 0, 32'h0,         32'h0000_0180, 0, 0, 64'h0, 64'h0,                  64'h600, 1, 0, 32'h0000_0180};
        tbl[7]  = '{0, 1, 1, 0, 32'h1111_1111, 32'h2222_2222, 2, 1, 64'h1000, 64'h0,               64'h0,   0, 1, 32'h1111_1100};
        tbl[8]  = '{0, 0, 1, 0, 32'h0,         32'h2222_2222, 1, 1, 64'h0, 64'h0,                  64'h800, 1, 0, 32'h2222_2200};
        tbl[9]  = '{1, 1, 0, 0, 32'h0BAD_F00D, 32'h0,         0, 0, 64'h9000, 64'h0,               64'h0,   0, 1, 32'h0BAD_F000};
        tbl[10] = '{1, 0, 1, 1, 32'h0000_5000, 32'hDEAD_BEEF, 1, 0, 64'h0, 64'hD000,               64'h0,   1, 1, 32'hDEAD_BE80};
        tbl[11] = '{1, 0, 0, 0, 32'h0000_5000, 32'h0,         0, 0, 64'h0, 64'h0,                  64'hB00, 0, 0, 32'h0000_5000};

        rst = 1'b1;
        i_read = 0; i_write = 0; d_read = 0; d_write = 0;
        i_address = '0; d_address = '0; i_wdata = '0; d_wdata = '0;
        bmem_rdata = '0; bmem_resp = 1'b0;
        model_last = 1'b0; model_i = '0; model_d = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset bmem_read", 64'(bmem_read), 64'd0);
        chk("reset bmem_write", 64'(bmem_write), 64'd0);
        chk("reset bmem_address", 64'(bmem_address), 64'd0);
        chk("reset bmem_wdata", bmem_wdata, 64'd0);
        chk("reset resp", 64'({i_resp, d_resp}), 64'd0);
        chk_line("reset i_rdata", i_rdata, '0);
        chk_line("reset d_rdata", d_rdata, '0);
        @(posedge clk); #1;
        rst = 1'b0;

        for (int v = 0; v < 12; v++) begin
            i_wdata = seq_line(tbl[v].iseed);
            d_wdata = seq_line(tbl[v].dseed);
            set_rd_seq(tbl[v].rseed);
            do_txn($sformatf("vec%0d", v), tbl[v].ir, tbl[v].iw, tbl[v].dr, tbl[v].dw,
                   tbl[v].ia, tbl[v].da, tbl[v].gap, tbl[v].noise,
                   tbl[v].exp_d, tbl[v].exp_wr, tbl[v].exp_addr);
        end

        // Reset arriving in the middle of a write burst.
        i_wdata = seq_line(64'h7700);
        i_address = 32'h0000_4400;
        i_write = 1'b1;
        repeat (6) @(posedge clk);
        @(negedge clk);
        chk("midrst write active", 64'(bmem_write), 64'd1);
        chk("midrst beat6 data", bmem_wdata, 64'h7705);
        @(posedge clk); #1;
        rst = 1'b1;
        i_write = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("midrst bmem_write", 64'(bmem_write), 64'd0);
        chk("midrst bmem_read", 64'(bmem_read), 64'd0);
        chk("midrst bmem_address", 64'(bmem_address), 64'd0);
        chk("midrst bmem_wdata", bmem_wdata, 64'd0);
        chk("midrst resp", 64'({i_resp, d_resp}), 64'd0);
        chk_line("midrst i_rdata", i_rdata, '0);
        chk_line("midrst d_rdata", d_rdata, '0);
        @(posedge clk); #1;
        rst = 1'b0;
        model_last = 1'b0; model_i = '0; model_d = '0;
        begin
            int busy;
            busy = 0;
            for (int c = 0; c < 20; c++) begin
                @(negedge clk);
                if (bmem_read || bmem_write || i_resp || d_resp) busy++;
            end
            chk("post-reset quiet", 64'(busy), 64'd0);
        end
        @(posedge clk); #1;
        set_rd_seq(64'hC0DE_0000);
        do_txn("post-reset I read", 1, 0, 0, 0, 32'h0000_6040, 32'h0, 0, 0, 0, 0, 32'h0000_6000);

        // Randomized traffic checked against the round-robin model.
        for (int it = 0; it < 40; it++) begin
            sel = $urandom_range(1, 3);
            ir = 0; iw = 0; dr = 0; dw = 0;
            if (sel != 2) begin
                case ($urandom_range(0, 2))
                    0: ir = 1;
                    1: iw = 1;
                    default: begin ir = 1; iw = 1; end
                endcase
            end
            if (sel != 1) begin
                case ($urandom_range(0, 2))
                    0: dr = 1;
                    1: dw = 1;
                    default: begin dr = 1; dw = 1; end
                endcase
            end
            ia = $urandom; da = $urandom;
            gap = $urandom_range(0, 2);
            noise = 1'($urandom_range(0, 1));
            i_wdata = rand_line(); d_wdata = rand_line();
            set_rd_rand();
            exp_d  = (sel == 2) || (sel == 3 && !model_last);
            exp_wr = exp_d ? dw : iw;
            do_txn($sformatf("rnd%0d", it), ir, iw, dr, dw, ia, da, gap, noise,
                   exp_d, exp_wr, (exp_d ? da : ia) & LINE_MASK);
            if (sel == 3) begin
                set_rd_rand();
                gap = $urandom_range(0, 2);
                if (exp_d)
                    do_txn($sformatf("rnd%0d loser", it), ir, iw, 0, 0, ia, da, gap, 0,
                           0, iw, ia & LINE_MASK);
                else
                    do_txn($sformatf("rnd%0d loser", it), 0, 0, dr, dw, ia, da, gap, 0,
                           1, dw, da & LINE_MASK);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
